// File: rtl/mxu_result_collector_if.sv
// -----------------------------------------------------------------------------
// mxu_result_collector_if
//
// Purpose:
//   Bundles the signals between the MXU result collector, the systolic array
//   that feeds it, and the downstream consumer of the aligned result vectors.
//
// Signals:
//   enable       array clock-enable; de-skew and latency counting follow it
//   start        one-cycle pulse that begins a collection pass
//   num_vectors  number of result vectors to collect in the pass
//   y            skewed array output bus, lane i at [(i+1)*W-1 : i*W]
//   out_data     aligned vector at the FIFO head
//   out_valid    FIFO holds at least one vector
//   out_ready    downstream accepts out_data
//   mxu_hold     FIFO is nearly full; upstream gates enable with it
//   busy         a pass is in progress
//   done         one-cycle pulse at the end of a pass
//   overflow     sticky flag: an aligned vector was dropped
//
// Modports:
//   master  the environment (array control + downstream consumer)
//   slave   the collector itself
// -----------------------------------------------------------------------------
interface mxu_result_collector_if #(
    parameter int M              = 3,
    parameter int max_data_width = 8,
    parameter int CNT_W          = 16
);
    logic                        enable;
    logic                        start;
    logic [CNT_W-1:0]            num_vectors;
    logic [M*max_data_width-1:0] y;
    logic [M*max_data_width-1:0] out_data;
    logic                        out_valid;
    logic                        out_ready;
    logic                        mxu_hold;
    logic                        busy;
    logic                        done;
    logic                        overflow;

    modport master (
        output enable, start, num_vectors, y, out_ready,
        input  out_data, out_valid, mxu_hold, busy, done, overflow
    );

    modport slave (
        input  enable, start, num_vectors, y, out_ready,
        output out_data, out_valid, mxu_hold, busy, done, overflow
    );
endinterface

// File: rtl/mxu_result_collector.sv
// -----------------------------------------------------------------------------
// mxu_result_collector
//
// Purpose:
//   Drain side of the MXU systolic array. Lane i of the array's y bus runs
//   i enabled cycles behind lane 0; this block delays each lane so that all M
//   lanes of one result vector line up, captures the aligned vectors into a
//   small FIFO and hands them downstream over valid/ready. It asks the array
//   to hold when the FIFO is nearly full and flags vectors it had to drop.
//
// Ports:
//   clk    rising-edge clock for all logic
//   reset  synchronous, active-low reset
//   bus    mxu_result_collector_if.slave (see interface header for signals)
// -----------------------------------------------------------------------------
module mxu_result_collector #(
    parameter int M              = 3,
    parameter int max_data_width = 8,
    parameter int PIPE_LAT       = 4,
    parameter int FIFO_DEPTH     = 4,
    parameter int CNT_W          = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    mxu_result_collector_if.slave bus
);
    localparam int W     = max_data_width;
    localparam int LW    = M * W;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LAT_W = $clog2(PIPE_LAT + M);

    // Enabled-cycle index at which vector 0 is fully aligned.
    localparam logic [LAT_W-1:0] CAP_IDX  = LAT_W'(PIPE_LAT + M - 1);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   HOLD_CNT = (PTR_W + 1)'(FIFO_DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_LAT,
        CAPTURE,
        DRAIN,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  num_q, num_d;
    logic [CNT_W-1:0]  vec_cnt_q, vec_cnt_d;
    logic [CNT_W-1:0]  vec_cnt_inc;
    logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
    logic              overflow_q, overflow_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    fifo_cnt_q, fifo_cnt_d;
    logic [LW-1:0]     mem_q [FIFO_DEPTH];
    logic [LW-1:0]     mem_d [FIFO_DEPTH];

    logic [LW-1:0]     aligned;
    logic              busy_o;
    logic              done_o;
    logic              start_accept;
    logic              capture;
    logic              last_vec;
    logic              fifo_full;
    logic              fifo_valid;
    logic              pop;
    logic              push;

    // De-skew lines: lane i is delayed by M-1-i enabled cycles so it lines up
    // with the top lane, which is taken straight from y.
    for (genvar i = 0; i < M - 1; i++) begin : g_lane
        localparam int D = M - 1 - i;

        logic [W-1:0] line_q [D];
        logic [W-1:0] line_d [D];

        // Shift the lane one stage per enabled cycle; hold otherwise.
        always_comb begin
            line_d = line_q;
            if (bus.enable) begin
                line_d[0] = bus.y[i*W +: W];
                for (int k = 1; k < D; k++) begin
                    line_d[k] = line_q[k-1];
                end
            end
        end

        // Lane delay registers, cleared on reset.
        always_ff @(posedge clk) begin
            if (!reset) begin
                for (int k = 0; k < D; k++) begin
                    line_q[k] <= '0;
                end
            end else begin
                line_q <= line_d;
            end
        end

        assign aligned[i*W +: W] = line_q[D-1];
    end

    assign aligned[(M-1)*W +: W] = bus.y[(M-1)*W +: W];

    assign vec_cnt_inc = vec_cnt_q + 1'b1;
    assign last_vec    = (vec_cnt_inc == num_q);
    assign fifo_full   = (fifo_cnt_q == FULL_CNT);
    assign fifo_valid  = (fifo_cnt_q != '0);
    assign pop         = fifo_valid && bus.out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push        = capture && (!fifo_full || pop);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = (bus.num_vectors == '0) ? DONE : WAIT_LAT;
                end
            end
            WAIT_LAT: begin
                if (capture) begin
                    state_d = last_vec ? DRAIN : CAPTURE;
                end
            end
            CAPTURE: begin
                if (capture && last_vec) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!fifo_valid) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM outputs. Capture happens on the enabled cycle where vector 0 first
    // lines up and on every enabled cycle after that until the pass is full.
    always_comb begin
        busy_o       = (state_q != IDLE);
        done_o       = (state_q == DONE);
        start_accept = (state_q == IDLE) && bus.start;
        capture      = bus.enable &&
                       (((state_q == WAIT_LAT) && (lat_cnt_q == CAP_IDX)) ||
                        (state_q == CAPTURE));
    end

    // Datapath next-state: pass counters, overflow flag and FIFO.
    always_comb begin
        num_d      = num_q;
        vec_cnt_d  = vec_cnt_q;
        lat_cnt_d  = lat_cnt_q;
        overflow_d = overflow_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        mem_d      = mem_q;

        // The start cycle is enabled-cycle 0 when enable is high, so the next
        // enabled cycle is index 1.
        if (start_accept) begin
            num_d      = bus.num_vectors;
            vec_cnt_d  = '0;
            lat_cnt_d  = bus.enable ? LAT_W'(1) : '0;
            overflow_d = 1'b0;
        end else if ((state_q == WAIT_LAT) && bus.enable && !capture) begin
            lat_cnt_d = lat_cnt_q + 1'b1;
        end

        // Dropped vectors still count so the pass always terminates.
        if (capture) begin
            vec_cnt_d = vec_cnt_inc;
        end
        if (capture && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end

        if (push) begin
            mem_d[wr_ptr_q] = aligned;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    // Datapath registers. FIFO storage is cleared too so out_data reads 0
    // after reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            num_q      <= '0;
            vec_cnt_q  <= '0;
            lat_cnt_q  <= '0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                mem_q[k] <= '0;
            end
        end else begin
            num_q      <= num_d;
            vec_cnt_q  <= vec_cnt_d;
            lat_cnt_q  <= lat_cnt_d;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            mem_q      <= mem_d;
        end
    end

    assign bus.out_data  = mem_q[rd_ptr_q];
    assign bus.out_valid = fifo_valid;
    assign bus.mxu_hold  = (fifo_cnt_q >= HOLD_CNT);
    assign bus.busy      = busy_o;
    assign bus.done      = done_o;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_mxu_result_collector.sv
// -----------------------------------------------------------------------------
// tb_mxu_result_collector
//
// Purpose:
//   Self-checking bench for mxu_result_collector. Each pass drives the y bus
//   as the array would (lane i of vector v on enabled-cycle PIPE_LAT+v+i) and
//   follows the pass with a queue model: vector v is due at enabled-cycle
//   PIPE_LAT+M-1+v, is kept if the queue has room or the head leaves that
//   cycle, and is otherwise dropped with overflow raised.
//
// Ports: none (top-level bench). Instantiates mxu_result_collector_if and
// the collector, and generates clk.
// -----------------------------------------------------------------------------
module tb_mxu_result_collector;
    localparam int M        = 3;
    localparam int W        = 8;
    localparam int PIPE_LAT = 4;
    localparam int DEPTH    = 4;
    localparam int CNT_W    = 16;
    localparam int LW       = M * W;
    localparam int CAP      = PIPE_LAT + M - 1;
    localparam int BUDGET   = 400;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    logic [LW-1:0] pass_data [64];
    logic [LW-1:0] mq [$];
    bit            m_ovf = 1'b0;

    mxu_result_collector_if #(.M(M), .max_data_width(W), .CNT_W(CNT_W)) bus ();

    mxu_result_collector #(
        .M(M), .max_data_width(W), .PIPE_LAT(PIPE_LAT),
        .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // One comparison: counts it and reports a mismatch.
    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drives every collector input for the coming clock edge.
    task automatic apply_stimulus(input bit st, input logic [CNT_W-1:0] num,
                                  input bit en, input bit rdy, input logic [LW-1:0] yv);
        bus.start       = st;
        bus.num_vectors = num;
        bus.enable      = en;
        bus.out_ready   = rdy;
        bus.y           = yv;
    endtask

    // Every output must read 0 right after a reset.
    task automatic check_reset_outputs(input string name);
        check_output({name, ".out_valid"}, 64'(bus.out_valid), 64'(0));
        check_output({name, ".out_data"},  64'(bus.out_data),  64'(0));
        check_output({name, ".busy"},      64'(bus.busy),      64'(0));
        check_output({name, ".done"},      64'(bus.done),      64'(0));
        check_output({name, ".overflow"},  64'(bus.overflow),  64'(0));
        check_output({name, ".mxu_hold"},  64'(bus.mxu_hold),  64'(0));
    endtask

    // One collection pass.
    //   en_mode: 0 always on, 1 obeys mxu_hold, 2 toggles 1,0,..., 3 random+hold
    //   ready_release: out_ready low before this cycle; negative = random
    //   base: lane i of vector v = base+16v+i; negative = random data
    //   stray: pulse start again mid-pass; abort_cyc: reset at that cycle
    task automatic run_pass(input string name, input int n, input int en_mode,
                            input int ready_release, input int base,
                            input bit stray, input int abort_cyc);
        int            ecnt;
        int            cap_cnt;
        bit            finishing;
        bit            finished;
        bit            en;
        bit            rdy;
        bit            pop;
        bit            push;
        logic [LW-1:0] yv;

        ecnt      = 0;
        cap_cnt   = 0;
        finishing = 1'b0;
        finished  = 1'b0;

        for (int v = 0; v < n; v++) begin
            for (int i = 0; i < M; i++) begin
                pass_data[v][i*W +: W] = (base < 0) ? W'($urandom) : W'(base + v*16 + i);
            end
        end

        for (int cyc = 0; cyc < BUDGET && !finished; cyc++) begin
            check_output({name, ".out_valid"}, 64'(bus.out_valid), 64'(mq.size() > 0));
            check_output({name, ".mxu_hold"},  64'(bus.mxu_hold),  64'(mq.size() >= DEPTH - 1));
            check_output({name, ".overflow"},  64'(bus.overflow),  64'(m_ovf));
            if (cyc == 1) begin
                check_output({name, ".busy_after_start"}, 64'(bus.busy), 64'(1));
            end

            if (finishing) begin
                check_output({name, ".busy_after_done"}, 64'(bus.busy), 64'(0));
                check_output({name, ".done_one_cycle"},  64'(bus.done), 64'(0));
                finished = 1'b1;
            end else if (bus.done) begin
                check_output({name, ".done_at_end"},
                             64'((cap_cnt == n) && (mq.size() == 0)), 64'(1));
                finishing = 1'b1;
            end

            if (!finished) begin
                if (cyc == abort_cyc) begin
                    reset = 1'b0;
                    bus.start = 1'b0;
                    @(negedge clk);
                    reset = 1'b1;
                    check_reset_outputs({name, ".after_reset"});
                    mq.delete();
                    m_ovf = 1'b0;
                    repeat (10) begin
                        @(negedge clk);
                        check_output({name, ".no_done"}, 64'(bus.done), 64'(0));
                        check_output({name, ".idle"},    64'(bus.busy), 64'(0));
                    end
                    return;
                end

                rdy = (ready_release < 0) ? 1'($urandom_range(0, 1)) : (cyc >= ready_release);
                case (en_mode)
                    0:       en = 1'b1;
                    1:       en = !bus.mxu_hold;
                    2:       en = (cyc % 2 == 0);
                    default: en = (cyc == 0) || (($urandom_range(0, 1) == 1) && !bus.mxu_hold);
                endcase

                for (int i = 0; i < M; i++) begin
                    int v;
                    v = ecnt - PIPE_LAT - i;
                    if (en && v >= 0 && v < n) begin
                        yv[i*W +: W] = pass_data[v][i*W +: W];
                    end else begin
                        yv[i*W +: W] = W'($urandom);
                    end
                end

                apply_stimulus((cyc == 0) || (stray && cyc == 9),
                               (cyc == 0) ? CNT_W'(n) : CNT_W'(1), en, rdy, yv);

                pop  = (mq.size() > 0) && rdy;
                push = 1'b0;
                if (cyc == 0) begin
                    m_ovf = 1'b0;
                end
                if (en && ecnt >= CAP && ecnt < CAP + n) begin
                    cap_cnt++;
                    if (mq.size() == DEPTH && !pop) begin
                        m_ovf = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                end
                if (pop) begin
                    check_output({name, ".out_data"}, 64'(bus.out_data), 64'(mq[0]));
                    void'(mq.pop_front());
                end
                if (push) begin
                    mq.push_back(pass_data[ecnt - CAP]);
                end
                if (en) begin
                    ecnt++;
                end

                @(negedge clk);
            end
        end

        if (!finished) begin
            check_output({name, ".timeout"}, 64'(0), 64'(1));
        end
    endtask

    // Directed sequence of passes.
    initial begin
        reset = 1'b0;
        apply_stimulus(1'b0, '0, 1'b0, 1'b0, '0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        check_reset_outputs("reset");

        $display("[TB] single vector");
        run_pass("single", 1, 0, 0, 16, 1'b0, -1);
        $display("[TB] stream of 8 with stray start");
        run_pass("stream", 8, 0, 0, 0, 1'b1, -1);
        $display("[TB] backpressure, hold obeyed");
        run_pass("hold", 6, 1, 30, -1, 1'b0, -1);
        $display("[TB] backpressure, hold ignored");
        run_pass("nohold", 6, 0, 30, -1, 1'b0, -1);
        check_output("nohold.sticky", 64'(bus.overflow), 64'(1));
        $display("[TB] enable bubbles");
        run_pass("bubble", 3, 2, 0, -1, 1'b0, -1);
        $display("[TB] zero vectors");
        run_pass("zero", 0, 0, 0, -1, 1'b0, -1);
        $display("[TB] random passes");
        run_pass("rand0", 7, 3, -1, -1, 1'b0, -1);
        run_pass("rand1", 9, 3, -1, -1, 1'b0, -1);
        $display("[TB] reset mid-capture");
        run_pass("abort", 8, 0, 0, -1, 1'b0, 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
